// File: rtl/nibble_serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// cpu_alu_pkg
// Shared definitions for the FreeCPU nibble-serial add/subtract unit.
//   state_t : sequencer states (IDLE accepts operands, RUN walks the nibbles,
//             DONE presents the result)
//   SLICE_W : width of the carry-lookahead slice processed per cycle
// ---------------------------------------------------------------------------
package cpu_alu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int SLICE_W = 4;

endpackage

// File: rtl/nibble_serial_adder_cla_slice4.sv
// ---------------------------------------------------------------------------
// cla_slice4
// Combinational 4-bit carry-lookahead adder slice.
//   c_in  : carry into bit 0
//   a, b  : 4-bit addends
//   out   : 4-bit sum
//   c_out : carry out of bit 3
// ---------------------------------------------------------------------------
module cla_slice4
   import cpu_alu_pkg::*;
(
   input  logic               c_in,
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   output logic [SLICE_W-1:0] out,
   output logic               c_out
);

   logic [SLICE_W-1:0] g;
   logic [SLICE_W-1:0] p;
   logic [SLICE_W-1:0] c;

   assign g = a & b;
   assign p = a ^ b;

   // Every carry is flattened to generate/propagate terms of c_in, so no
   // carry ripples through another carry.
   assign c[0] = c_in;
   assign c[1] = g[0] | (p[0] & c_in);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c_in);
   assign c_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c_in);

   assign out = p ^ c;

endmodule

// File: rtl/nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder
// Multi-cycle add/subtract unit: WIDTH-bit operands are summed one nibble per
// cycle through a single 4-bit lookahead slice, the carry held in a register
// between cycles.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  : operand handshake (accepted only in IDLE)
//   a, b, sub, c_in     : operands; sub inverts b, c_in is the carry in
//   out_valid, out_ready: result handshake (result held in DONE)
//   sum, c_out, overflow: result, MSB carry, signed overflow
//   busy                : high while an operation is in RUN or DONE
// ---------------------------------------------------------------------------
module nibble_serial_adder
   import cpu_alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             overflow,
   output logic             busy
);

   localparam int NIBBLES = WIDTH / SLICE_W;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   generate
      if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
         $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
      end
   endgenerate

   state_t             state;
   state_t             next_state;
   logic [IDX_W-1:0]   idx;
   logic               carry;
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic [SLICE_W-1:0] nib_a;
   logic [SLICE_W-1:0] nib_b;
   logic [SLICE_W-1:0] nib_sum;
   logic               nib_c;
   logic               accept;
   logic               last;

   assign accept = in_valid && in_ready;
   assign last   = (idx == IDX_W'(NIBBLES - 1));

   // Select the operand nibble addressed by idx.
   always_comb begin
      nib_a = '0;
      nib_b = '0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx == IDX_W'(i)) begin
            nib_a = op_a[i*SLICE_W +: SLICE_W];
            nib_b = op_b[i*SLICE_W +: SLICE_W];
         end
      end
   end

   cla_slice4 u_slice (
      .c_in  (carry),
      .a     (nib_a),
      .b     (nib_b),
      .out   (nib_sum),
      .c_out (nib_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) next_state = RUN;
         end
         RUN: begin
            if (last) next_state = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Operands are captured once at accept; b is stored already inverted for
   // subtract so overflow can be judged on the operand actually added.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_a <= a;
         op_b <= sub ? ~b : b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx      <= '0;
         carry    <= 1'b0;
         sum      <= '0;
         c_out    <= 1'b0;
         overflow <= 1'b0;
      end else if (accept) begin
         idx   <= '0;
         carry <= c_in;
      end else if (state == RUN) begin
         idx   <= last ? '0 : idx + IDX_W'(1);
         carry <= nib_c;
         for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) sum[i*SLICE_W +: SLICE_W] <= nib_sum;
         end
         // On the top nibble the slice output holds the result sign bit.
         if (last) begin
            c_out    <= nib_c;
            overflow <= (op_a[WIDTH-1] == op_b[WIDTH-1])
                     && (nib_sum[SLICE_W-1] != op_a[WIDTH-1]);
         end
      end
   end

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

   localparam int W = 32;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          sub;
   logic          c_in;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  sum;
   logic          c_out;
   logic          overflow;
   logic          busy;

   int n_checks = 0;
   int n_pass   = 0;

   nibble_serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out),
      .overflow  (overflow),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Run one operation with out_ready held low until the result appears.
   task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tsub, input logic tcin,
                         input logic [W-1:0] esum, input logic ec, input logic eov);
      int cnt;
      a = ta; b = tb_; sub = tsub; c_in = tcin; in_valid = 1'b1;
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = ~ta; b = ~tb_; sub = ~tsub; c_in = ~tcin;   // later operand changes must not matter
      cnt = 0;
      while (!out_valid && cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
      end
      check({tag, "_latency"}, 64'(cnt), 64'd8);
      check({tag, "_sum"}, 64'(sum), 64'(esum));
      check({tag, "_c_out"}, 64'(c_out), 64'(ec));
      check({tag, "_ovf"}, 64'(overflow), 64'(eov));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_idle"}, 64'({in_ready, out_valid, busy}), 64'b100);
   endtask

   logic [W-1:0] ra [4];
   logic [W-1:0] rb [4];
   logic         rs [4];
   logic         rc [4];
   logic [W:0]   rexp [4];
   logic         rov [4];
   int           acc_cyc [4];

   initial begin
      logic [W-1:0] bb;
      int cnt;
      int k;
      int r;
      logic prev_ready;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; sub = 1'b0; c_in = 1'b0;
      #3;
      check("rst_ctrl", 64'({in_ready, out_valid, busy}), 64'b100);
      check("rst_sum", 64'(sum), 64'd0);
      check("rst_flags", 64'({c_out, overflow}), 64'b00);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("add_wrap", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      run_op("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

      // Backpressure in DONE while new operands are offered.
      a = 32'h0000_0010; b = 32'h0000_0020; sub = 1'b0; c_in = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cnt = 0;
      while (!out_valid && cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
      end
      check("bp_latency", 64'(cnt), 64'd8);
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0] ? 1'b0 : 1'b1;
         a = 32'hDEAD_0000 + 32'(i); b = 32'h0BAD_F00D;
         check("bp_sum", 64'(sum), 64'h30);
         check("bp_flags", 64'({c_out, overflow}), 64'b00);
         check("bp_ctrl", 64'({in_ready, out_valid, busy}), 64'b011);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("bp_held_sum", 64'(sum), 64'h30);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp_release", 64'({in_ready, out_valid, busy}), 64'b100);

      // Asynchronous reset in the middle of RUN (idx=3).
      a = 32'hFFFF_FFFF; b = 32'h0000_0001; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("mid_busy", 64'({in_ready, out_valid, busy}), 64'b001);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_ctrl", 64'({in_ready, out_valid, busy}), 64'b100);
      check("mid_rst_sum", 64'(sum), 64'd0);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

      // Back-to-back streaming against a reference model.
      for (int i = 0; i < 4; i++) begin
         ra[i] = $urandom; rb[i] = $urandom;
         rs[i] = 1'($urandom_range(1, 0)); rc[i] = 1'($urandom_range(1, 0));
         bb = rs[i] ? ~rb[i] : rb[i];
         rexp[i] = {1'b0, ra[i]} + {1'b0, bb} + {{W{1'b0}}, rc[i]};
         rov[i] = (ra[i][W-1] == bb[W-1]) && (rexp[i][W-1] != ra[i][W-1]);
         acc_cyc[i] = 0;
      end
      out_ready = 1'b1;
      k = 0; r = 0;
      a = ra[0]; b = rb[0]; sub = rs[0]; c_in = rc[0]; in_valid = 1'b1;
      prev_ready = in_ready;
      for (int cyc = 0; cyc < 60 && r < 4; cyc++) begin
         @(posedge clk); #1;
         if (prev_ready && k < 4) begin
            acc_cyc[k] = cyc;
            k++;
            if (k < 4) begin
               a = ra[k]; b = rb[k]; sub = rs[k]; c_in = rc[k];
            end else begin
               in_valid = 1'b0;
            end
         end
         if (out_valid) begin
            check("stream_sum", 64'(sum), 64'(rexp[r][W-1:0]));
            check("stream_c_out", 64'(c_out), 64'(rexp[r][W]));
            check("stream_ovf", 64'(overflow), 64'(rov[r]));
            r++;
         end
         prev_ready = in_ready;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      check("stream_results", 64'(r), 64'd4);
      for (int i = 1; i < 4; i++) begin
         check("stream_interval", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd10);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
